ccd_capture_ctrl: RTL

CCD_CAPTURE_CTRL -- requirements
Module: ccd_capture_ctrl

---
 rtl/ccd_capture_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ccd_capture_ctrl.sv
// CCD frame capture controller. Sequences AD9945 configuration, arms on the
// line driver's shift gate, gates pixel capture for a whole number of lines
// and applies host integration/gain updates only at line boundaries.
module ccd_capture_ctrl #(
  parameter logic [22:0] DEF_F_CNT = 23'd20000,
  parameter logic [9:0]  DEF_GAIN  = 10'd0,
  parameter logic [15:0] CFG_WAIT  = 16'd1000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic [10:0] rows,
  input  logic        host_wr,
  input  logic [22:0] host_f_cnt,
  input  logic [9:0]  host_gain,
  input  logic        sh,
  output logic [22:0] f_cnt,
  output logic [9:0]  vga_gain,
  output logic        cfg_en,
  output logic        capture_en,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CONFIG, ARM, CAPTURE} state_t;

  // Last CONFIG cycle index; a zero wait still spends one cycle in CONFIG.
  localparam logic [15:0] CFG_LAST = (CFG_WAIT == 16'd0) ? 16'd0 : CFG_WAIT - 16'd1;

  state_t      state, state_next;
  logic        sh_prev;
  logic        sh_rise;
  logic [22:0] f_shadow;
  logic [9:0]  g_shadow;
  logic        f_pend, g_pend;
  logic        cfg_done;
  logic        stop_seen;
  logic [15:0] cfg_cnt;
  logic [10:0] rows_lat;
  logic [10:0] line_cnt;
  logic [10:0] rows_eff;
  logic        load_rows;
  logic        frame_end;
  logic        enter_cfg;
  logic        apply_f;

  assign sh_rise   = sh & ~sh_prev;
  assign rows_eff  = (rows == 11'd0) ? 11'd1 : rows;
  assign enter_cfg = (state_next == CONFIG) && (state != CONFIG);
  assign apply_f   = f_pend && (sh_rise || (state == IDLE));

  assign busy       = (state != IDLE);
  assign capture_en = (state == CAPTURE);
  assign cfg_en     = (state == CONFIG) && (cfg_cnt == 16'd0);

  // State register.
  always_ff @(posedge sys_clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the one-cycle frame/row-load strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_next = state;
    load_rows  = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          load_rows  = 1'b1;
          state_next = (g_pend || !cfg_done) ? CONFIG : ARM;
        end
      end
      CONFIG: begin
        // Configuration always runs to completion; stop only redirects the exit.
        if (cfg_cnt == CFG_LAST) state_next = (stop_seen || stop) ? IDLE : ARM;
      end
      ARM: begin
        if (stop || stop_seen) state_next = IDLE;
        else if (sh_rise)      state_next = CAPTURE;
      end
      CAPTURE: begin
        if (sh_rise && (line_cnt == rows_lat - 11'd1)) begin
          frame_end = 1'b1;
          if (stop_seen || stop || !continuous) begin
            state_next = IDLE;
          end else begin
            load_rows  = 1'b1;
            state_next = g_pend ? CONFIG : ARM;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line/config counters, frame bookkeeping and the stop request latch.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sh_prev    <= 1'b0;
      cfg_cnt    <= 16'd0;
      cfg_done   <= 1'b0;
      stop_seen  <= 1'b0;
      rows_lat   <= 11'd1;
      line_cnt   <= 11'd0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      sh_prev    <= sh;
      frame_done <= frame_end;

      if (state != CONFIG)          cfg_cnt <= 16'd0;
      else if (cfg_cnt != CFG_LAST) cfg_cnt <= cfg_cnt + 16'd1;

      if ((state == CONFIG) && (cfg_cnt == CFG_LAST)) cfg_done <= 1'b1;

      if (state_next == IDLE)             stop_seen <= 1'b0;
      else if (stop && (state != IDLE))   stop_seen <= 1'b1;

      if (load_rows) rows_lat <= rows_eff;

      if (frame_end)                                   line_cnt <= 11'd0;
      else if ((state == ARM) && sh_rise)              line_cnt <= 11'd0;
      else if ((state == CAPTURE) && sh_rise)          line_cnt <= line_cnt + 11'd1;

      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Host shadow registers: integration count moves at a line boundary
  // (or straight away when idle), gain moves on entry to CONFIG.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      f_cnt    <= DEF_F_CNT;
      f_shadow <= DEF_F_CNT;
      f_pend   <= 1'b0;
      vga_gain <= DEF_GAIN;
      g_shadow <= DEF_GAIN;
      g_pend   <= 1'b0;
    end else begin
      if (apply_f) begin
        f_cnt  <= f_shadow;
        f_pend <= 1'b0;
      end
      if (enter_cfg) begin
        vga_gain <= g_shadow;
        g_pend   <= 1'b0;
      end
      if (host_wr) begin
        f_shadow <= host_f_cnt;
        g_shadow <= host_gain;
        // A write landing on the applying line edge stays queued for the next one.
        if (state == IDLE) begin
          f_cnt  <= host_f_cnt;
          f_pend <= 1'b0;
        end else begin
          f_pend <= 1'b1;
        end
        if (host_gain != vga_gain) g_pend <= 1'b1;
      end
    end
  end

endmodule
